// File: rtl/bb_pkg.sv
// Baseband types and constants shared by the serial-to-parallel converter
// and the signal mapper.
package bb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SYM_W         = 2;
    localparam int DEF_FRAME_LEN = 512;

    // Occupancy of a 2-entry FIFO after one edge; push+pop leaves it unchanged.
    function automatic logic [1:0] fifo_cnt_next(input logic [1:0] cnt,
                                                 input logic       push,
                                                 input logic       pop);
        logic [1:0] nxt;
        case ({push, pop})
            2'b10:   nxt = cnt + 2'd1;
            2'b01:   nxt = cnt - 2'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sp_convert_if.sv
// Bit-stream input and symbol output handshake of sp_convert.
interface sp_convert_if #(
    parameter int IDX_W = 9
);
    import bb_pkg::*;

    logic             start;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [SYM_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [IDX_W-1:0] dout_idx;
    logic             frame_done;
    logic             busy;

    modport master (
        output start, bit_in, bit_valid, dout_ready,
        input  bit_ready, dout, dout_valid, dout_idx, frame_done, busy
    );

    modport slave (
        input  start, bit_in, bit_valid, dout_ready,
        output bit_ready, dout, dout_valid, dout_idx, frame_done, busy
    );

endinterface

// File: rtl/sym_fifo2.sv
// Two-entry symbol FIFO with occupancy count; the head entry is always visible.
module sym_fifo2
    import bb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] head,
    output logic [1:0]       count
);

    logic [SYM_W-1:0] mem_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Illegal requests (pop when empty, push when full without a pop) are dropped.
    assign pop_ok_s  = pop && (cnt_r != 2'd0);
    assign push_ok_s = push && ((cnt_r != 2'd2) || pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= {SYM_W{1'b0}};
            mem_r[1] <= {SYM_W{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= fifo_cnt_next(cnt_r, push_ok_s, pop_ok_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = cnt_r;

endmodule

// File: rtl/sp_convert.sv
// Serial-to-parallel converter: packs bits MSB-first into 2-bit symbols and
// emits exactly FRAME_LEN indexed symbols per frame.
module sp_convert
    import bb_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input logic         clk,
    input logic         rst,
    sp_convert_if.slave sif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t           state_r;
    logic             phase_r;
    logic             hold_r;
    logic             bit_ready_r;
    logic             dout_valid_r;
    logic             frame_done_r;
    logic             busy_r;
    logic [IDX_W-1:0] in_cnt_r;
    logic [IDX_W-1:0] out_cnt_r;

    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             phase_nx_s;
    logic [1:0]       fifo_cnt_s;
    logic [1:0]       fifo_cnt_nx_s;
    logic [SYM_W-1:0] head_s;

    assign accept_s      = sif.bit_valid && bit_ready_r;
    assign push_s        = accept_s && phase_r;
    assign pop_s         = dout_valid_r && sif.dout_ready;
    assign phase_nx_s    = accept_s ? ~phase_r : phase_r;
    assign fifo_cnt_nx_s = fifo_cnt_next(fifo_cnt_s, push_s, pop_s);

    sym_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({hold_r, sif.bit_in}),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_cnt_s)
    );

    // Control FSM, bit packer and counters; every output is a register
    // computed from next-cycle state so dout_ready never reaches bit_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            phase_r      <= 1'b0;
            hold_r       <= 1'b0;
            in_cnt_r     <= {IDX_W{1'b0}};
            out_cnt_r    <= {IDX_W{1'b0}};
            bit_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            dout_valid_r <= (fifo_cnt_nx_s != 2'd0);
            if (accept_s) begin
                phase_r <= phase_nx_s;
                if (!phase_r) begin
                    hold_r <= sif.bit_in;
                end
            end
            if (push_s) begin
                in_cnt_r <= in_cnt_r + ONE_IDX;
            end
            // The index parks on the last symbol; only a new start rewinds it.
            if (pop_s && (out_cnt_r != LAST_IDX)) begin
                out_cnt_r <= out_cnt_r + ONE_IDX;
            end
            case (state_r)
                IDLE: begin
                    if (sif.start) begin
                        state_r     <= RUN;
                        phase_r     <= 1'b0;
                        in_cnt_r    <= {IDX_W{1'b0}};
                        out_cnt_r   <= {IDX_W{1'b0}};
                        busy_r      <= 1'b1;
                        bit_ready_r <= 1'b1;
                    end else begin
                        busy_r      <= 1'b0;
                        bit_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    busy_r <= 1'b1;
                    if (push_s && (in_cnt_r == LAST_IDX)) begin
                        state_r     <= DONE;
                        bit_ready_r <= 1'b0;
                    end else begin
                        bit_ready_r <= !(phase_nx_s && (fifo_cnt_nx_s == 2'd2));
                    end
                end
                DONE: begin
                    bit_ready_r <= 1'b0;
                    if (fifo_cnt_nx_s == 2'd0) begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    phase_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    bit_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign sif.bit_ready  = bit_ready_r;
    assign sif.dout       = head_s;
    assign sif.dout_valid = dout_valid_r;
    assign sif.dout_idx   = out_cnt_r;
    assign sif.frame_done = frame_done_r;
    assign sif.busy       = busy_r;

endmodule
